// File: rtl/addsub_pkg.sv
// Shared types for the pipelined add/subtract unit: op encoding and status flags.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } addsub_op_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } addsub_flags_t;

    function automatic logic op_inverts_b(addsub_op_t op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CW-bit ripple-carry slice; cmsb_in exposes the carry into the slice MSB for overflow.
module addsub_chunk #(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb_in
);
    logic w_carry;

    always_comb begin
        sum     = '0;
        cmsb_in = 1'b0;
        w_carry = cin;
        for (int i = 0; i < CW; i++) begin
            if (i == CW - 1) cmsb_in = w_carry;
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CW-bit chunk per stage, global stall on output backpressure.
// Define ADDSUB_SAT_EN to add the in_sat port and signed saturation in the last stage.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
`ifdef ADDSUB_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);
    localparam int unsigned CW  = WIDTH / STAGES;
    localparam int unsigned TOP = (STAGES - 1) * CW;

    // Bank k holds the beat about to have chunk k added: skew (a, b), deskew (sum).
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_z;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
`ifdef ADDSUB_SAT_EN
    logic [STAGES-1:0] r_sat;
`endif

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_result;
    addsub_flags_t     r_out_flags;

    logic [CW-1:0]     w_sum [STAGES];
    logic [STAGES-1:0] w_cout;
    logic              w_cmsb_top;
    addsub_op_t        w_op;
    logic              w_cin;
    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH-1:0]  w_raw;
    logic [WIDTH-1:0]  w_res;
    logic              w_v;
    logic              w_clamp;
    addsub_flags_t     w_flags;

    assign in_ready = !r_out_valid || out_ready;

    always_comb begin
        w_op    = addsub_op_t'(in_op);
        w_b_eff = op_inverts_b(w_op) ? ~in_b : in_b;
        case (w_op)
            OP_ADD:  w_cin = 1'b0;
            OP_SUB:  w_cin = 1'b1;
            default: w_cin = in_cin;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == STAGES - 1) begin : g_top
            addsub_chunk #(.CW(CW)) u_chunk (
                .a       (r_a[k][k*CW +: CW]),
                .b       (r_b[k][k*CW +: CW]),
                .cin     (r_c[k]),
                .sum     (w_sum[k]),
                .cout    (w_cout[k]),
                .cmsb_in (w_cmsb_top)
            );
        end else begin : g_low
            logic w_cmsb_unused;
            addsub_chunk #(.CW(CW)) u_chunk (
                .a       (r_a[k][k*CW +: CW]),
                .b       (r_b[k][k*CW +: CW]),
                .cin     (r_c[k]),
                .sum     (w_sum[k]),
                .cout    (w_cout[k]),
                .cmsb_in (w_cmsb_unused)
            );
        end
    end

    always_comb begin
        w_raw            = r_sum[STAGES-1];
        w_raw[TOP +: CW] = w_sum[STAGES-1];
        w_v              = w_cmsb_top ^ w_cout[STAGES-1];
        w_clamp          = 1'b0;
`ifdef ADDSUB_SAT_EN
        w_clamp          = r_sat[STAGES-1] & w_v;
`endif
        w_res = w_raw;
        // Raw MSB set on overflow means the true result was positive.
        if (w_clamp) w_res = {~w_raw[WIDTH-1], {(WIDTH-1){w_raw[WIDTH-1]}}};
        w_flags.c = w_cout[STAGES-1];
        w_flags.v = w_v;
        w_flags.n = w_res[WIDTH-1];
        w_flags.z = r_z[STAGES-1] & (w_sum[STAGES-1] == '0) & ~w_clamp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_c     <= '0;
            r_z     <= '0;
`ifdef ADDSUB_SAT_EN
            r_sat   <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
        end else if (in_ready) begin
            r_valid[0] <= in_valid;
            r_a[0]     <= in_a;
            r_b[0]     <= w_b_eff;
            r_c[0]     <= w_cin;
            r_z[0]     <= 1'b1;
            r_sum[0]   <= '0;
`ifdef ADDSUB_SAT_EN
            r_sat[0]   <= in_sat;
`endif
            for (int k = 0; k < STAGES - 1; k++) begin
                r_valid[k+1]             <= r_valid[k];
                r_a[k+1]                 <= r_a[k];
                r_b[k+1]                 <= r_b[k];
                r_sum[k+1]               <= r_sum[k];
                r_sum[k+1][k*CW +: CW]   <= w_sum[k];
                r_c[k+1]                 <= w_cout[k];
                r_z[k+1]                 <= r_z[k] & (w_sum[k] == '0);
`ifdef ADDSUB_SAT_EN
                r_sat[k+1]               <= r_sat[k];
`endif
            end
            r_out_valid  <= r_valid[STAGES-1];
            r_out_result <= w_res;
            r_out_flags  <= w_flags;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_c      = r_out_flags.c;
    assign out_v      = r_out_flags.v;
    assign out_z      = r_out_flags.z;
    assign out_n      = r_out_flags.n;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed beats push expectations into a queue,
// a separate monitor pops and compares whenever a result is presented.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic [1:0]   in_op     = 2'b00;
    logic         in_cin    = 1'b0;
    logic         in_sat    = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_c, out_v, out_z, out_n;

    typedef struct {
        logic [W-1:0] r;
        logic         c, v, z, n;
        bit           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   stall_lo = 0;
    int   stall_hi = 0;
    int   stall_obs = 0;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_cin     (in_cin),
`ifdef ADDSUB_SAT_EN
        .in_sat     (in_sat),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_v      (out_v),
        .out_z      (out_z),
        .out_n      (out_n)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        out_ready = !(cyc >= stall_lo && cyc < stall_hi);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [W-1:0] r,
                                input logic c, input logic v, input logic z, input logic n);
        exp_t e;
        e.r = r; e.c = c; e.v = v; e.z = z; e.n = n;
        e.lat = 1'b1; e.acc = 0; e.name = name;
        return e;
    endfunction

    // Straight 33-bit reference add; used for the mixed-op stream.
    function automatic exp_t model(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic cin);
        exp_t      e;
        logic [W-1:0] bb;
        logic      ci;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb   = op[0] ? ~b : b;
        ci   = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, ci};
        e.r = full[W-1:0]; e.c = full[W]; e.v = full[W] ^ low[W-1];
        e.z = (full[W-1:0] == '0); e.n = full[W-1];
        e.lat = 1'b0; e.acc = 0; e.name = name;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic cin, input logic sat, input exp_t e, input bit keep);
        int guard;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cin = cin; in_sat = sat;
        #1;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout %s: in_ready still 0 after %0d cycles", e.name, guard);
            in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (keep) exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        #3;
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compare every presented beat against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got result %h, expected no beat", out_result);
                end else begin
                    e = exp_q[0];
                    check(out_ready ? e.name : {e.name, "_stalled"},
                          {out_result, out_c, out_v, out_z, out_n}, {e.r, e.c, e.v, e.z, e.n});
                    if (!out_ready) begin
                        stall_obs++;
                        check("in_ready_during_stall", in_ready, 0);
                    end else begin
                        if (e.lat) check({e.name, "_latency"}, cyc - e.acc, S);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] sa, sb;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_outputs", {out_result, out_c, out_v, out_z, out_n}, 0);
        check("ready_after_reset", in_ready, 1);

        issue(32'h0000_00FF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, mk("add_ff_1", 32'h0000_0100, 0, 0, 0, 0), 1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, mk("add_wrap", 32'h0000_0000, 1, 0, 1, 0), 1);
        issue(32'h0000_0000, 32'h0000_0001, OP_SUB, 1'b0, 1'b0, mk("sub_0_1", 32'hFFFF_FFFF, 0, 0, 0, 1), 1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, mk("add_ovf", 32'h8000_0000, 0, 1, 0, 1), 1);
        issue(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 1'b0, mk("sub_ovf", 32'h7FFF_FFFF, 1, 1, 0, 0), 1);
        issue(32'h0000_0005, 32'h0000_0005, OP_SUB, 1'b0, 1'b0, mk("sub_eq", 32'h0000_0000, 1, 0, 1, 0), 1);
        issue(32'h00FF_00FF, 32'h0001_0001, OP_ADD, 1'b1, 1'b0, mk("add_chunk_carry", 32'h0100_0100, 0, 0, 0, 0), 1);
        issue(32'h0000_0003, 32'h0000_0001, OP_SUB, 1'b0, 1'b0, mk("sub_ignores_cin", 32'h0000_0002, 1, 0, 0, 0), 1);
        issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, mk("chain_lo", 32'h0000_0000, 1, 0, 1, 0), 1);
        issue(32'h0000_0001, 32'h0000_0000, OP_ADC, 1'b1, 1'b0, mk("chain_hi", 32'h0000_0002, 0, 0, 0, 0), 1);
        issue(32'h7FFF_FFFF, 32'h0000_0000, OP_ADC, 1'b1, 1'b0, mk("adc_ovf", 32'h8000_0000, 0, 1, 0, 1), 1);
        issue(32'h0000_0005, 32'h0000_0003, OP_SBC, 1'b0, 1'b0, mk("sbc_borrow", 32'h0000_0001, 1, 0, 0, 0), 1);
        issue(32'h0000_0005, 32'h0000_0003, OP_SBC, 1'b1, 1'b0, mk("sbc_noborrow", 32'h0000_0002, 1, 0, 0, 0), 1);
`ifdef ADDSUB_SAT_EN
        issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b1, mk("sat_pos", 32'h7FFF_FFFF, 0, 1, 0, 0), 1);
        issue(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 1'b1, mk("sat_neg", 32'h8000_0000, 1, 1, 0, 1), 1);
        issue(32'h0000_00FF, 32'h0000_0001, OP_ADD, 1'b0, 1'b1, mk("sat_no_ovf", 32'h0000_0100, 0, 0, 0, 0), 1);
`endif
        idle();
        drain("drain_directed");

        // Eight back-to-back beats with a three-cycle output stall mid-stream.
        @(negedge clk);
        stall_obs = 0;
        stall_lo  = cyc + 6;
        stall_hi  = cyc + 9;
        for (int i = 0; i < 8; i++) begin
            sa = 32'h1357_9BDF + W'(i) * 32'h1111_1111;
            sb = 32'h0F0F_F0F0 + W'(i) * 32'h0101_0101;
            issue(sa, sb, 2'(i % 4), 1'(i % 2), 1'b0,
                  model($sformatf("stream_%0d", i), sa, sb, 2'(i % 4), 1'(i % 2)), 1);
        end
        idle();
        drain("drain_stream");
        check("stall_cycles", stall_obs, 3);

        // Asynchronous reset with three beats in flight.
        issue(32'h0000_0011, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, mk("drop0", 0, 0, 0, 0, 0), 0);
        issue(32'h0000_0022, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, mk("drop1", 0, 0, 0, 0, 0), 0);
        issue(32'h0000_0033, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, mk("drop2", 0, 0, 0, 0, 0), 0);
        idle();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        check("async_reset_outputs", {out_result, out_c, out_v, out_z, out_n}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_no_stale", out_valid, 0);
        issue(32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0, 1'b0, mk("post_reset_add", 32'h2345_6789, 0, 0, 0, 0), 1);
        idle();
        drain("drain_post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
